ps2_key_event_unit: RTL and testbench

Parametrised PS/2 keyboard front end. It receives and validates PS/2 frames, including start, odd parity, stop bit and a watchdog timeout. It decodes the E0/F0 prefix sequences into make/break key events, buffers those events in a valid/ready FIFO, and maintains a held-key bitmap for a configurable key table. Game and control logic sit on its outputs; it replaces the fixed-key, unbuffered keyboard driver.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_frame_rx.sv | 99 +++++++++
 rtl/ps2_key_event_unit.sv | 157 +++++++++++++++
 tb/tb_ps2_key_event_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key event unit.
// Holds the decoder state enum, frame constants, special codes and event bundle.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0
    } dec_state_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [3:0] PS2_STOP_IDX   = 4'(PS2_FRAME_BITS - 1);

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;
    localparam logic [7:0] PS2_ECHO       = 8'hEE;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } ps2_event_t;

    // Status/reply bytes that never start a key sequence.
    function automatic logic is_idle_discard(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == 8'h00) || (b == 8'hFF) ||
               (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and filters PS2_CLK/PS2_DAT and receives 11-bit
// frames, flagging bad start/parity/stop bits and mid-frame timeouts.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [WW-1:0] wd_cnt;
    logic          clk_s;
    logic          dat_s;
    logic          filt_flip;
    logic          fall;
    logic          timeout;

    assign clk_s     = clk_sync[1];
    assign dat_s     = dat_sync[1];
    assign filt_flip = (clk_s != clk_filt) && (filt_cnt == FW'(FILT_LEN - 1));
    assign fall      = filt_flip && clk_filt;
    assign timeout   = (bit_cnt != 4'd0) && !fall &&
                       (wd_cnt == WW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            if (clk_s == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_flip) begin
                clk_filt <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // shreg fills LSB-first: after ten shifts [0]=start, [8:1]=data, [9]=parity.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bit_cnt    <= 4'd0;
            shreg      <= '0;
            wd_cnt     <= '0;
            rx_byte    <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                wd_cnt <= '0;
                if (bit_cnt == PS2_STOP_IDX) begin
                    bit_cnt <= 4'd0;
                    if (!shreg[0] && (^shreg[9:1]) && dat_s) begin
                        rx_byte    <= shreg[8:1];
                        byte_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {dat_s, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (timeout) begin
                bit_cnt   <= 4'd0;
                wd_cnt    <= '0;
                frame_err <= 1'b1;
            end else if (bit_cnt != 4'd0) begin
                wd_cnt <= wd_cnt + WW'(1);
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_unit.sv
// ps2_key_event_unit: PS/2 frame receiver, E0/F0 decoder, event FIFO and held-key
// bitmap. Define PS2_TYPEMATIC_FILTER_EN to drop repeated makes of held table keys.
module ps2_key_event_unit
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS    = 9,
    parameter logic [9*NUM_KEYS-1:0] KEY_TABLE   = {9'h059, 9'h026, 9'h01E,
                                                    9'h016, 9'h029, 9'h05A,
                                                    9'h07A, 9'h072, 9'h069},
    parameter int                    FIFO_DEPTH  = 8,
    parameter int                    FILT_LEN    = 8,
    parameter int                    TIMEOUT_CYC = 100000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                PS2_CLK,
    input  logic                PS2_DAT,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [7:0]          ev_code,
    output logic                ev_ext,
    output logic                ev_make,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                frame_err,
    output logic                overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]          rx_byte;
    logic                byte_valid;
    dec_state_t          state;
    dec_state_t          state_nx;
    logic                ev_fire;
    ps2_event_t          ev;
    logic [NUM_KEYS-1:0] key_hit;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                full;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_nx;
    logic [PW-1:0]       rd_nx;
    ps2_event_t          mem [FIFO_DEPTH];
    ps2_event_t          head;

    ps2_frame_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset || frame_err) state <= ST_IDLE;
        else                    state <= state_nx;
    end

    // Event fields follow from the state the byte arrives in.
    always_comb begin
        state_nx = state;
        ev_fire  = 1'b0;
        ev.code  = rx_byte;
        ev.ext   = (state == ST_E0) || (state == ST_E0F0);
        ev.make  = (state == ST_IDLE) || (state == ST_E0);
        if (byte_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (rx_byte == PS2_EXT)      state_nx = ST_E0;
                    else if (rx_byte == PS2_BRK) state_nx = ST_F0;
                    else ev_fire = !is_idle_discard(rx_byte);
                end
                ST_E0: begin
                    if (rx_byte == PS2_BRK) begin
                        state_nx = ST_E0F0;
                    end else begin
                        state_nx = ST_IDLE;
                        ev_fire  = (rx_byte != PS2_FAKE_SHIFT);
                    end
                end
                ST_F0: begin
                    state_nx = ST_IDLE;
                    ev_fire  = 1'b1;
                end
                ST_E0F0: begin
                    state_nx = ST_IDLE;
                    ev_fire  = (rx_byte != PS2_FAKE_SHIFT);
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        key_hit = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            key_hit[i] = (KEY_TABLE[9*i +: 9] == {ev.ext, ev.code});
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_down <= '0;
        end else if (ev_fire) begin
            for (int i = 0; i < NUM_KEYS; i++)
                if (key_hit[i]) key_down[i] <= ev.make;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign push_req = ev_fire && !(ev.make && |(key_hit & key_down));
`else
    assign push_req = ev_fire;
`endif

    assign pop   = ev_valid & ev_ready;
    assign full  = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
    assign push  = push_req && (!full || pop);
    assign wr_nx = wr_ptr + PW'(push);
    assign rd_nx = rd_ptr + PW'(pop);

    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr[AW-1:0]] <= ev;
    end

    // Head is registered; bypass the array when the new head is this push.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_valid <= 1'b0;
            head     <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_nx;
            rd_ptr   <= rd_nx;
            ev_valid <= (wr_nx != rd_nx);
            if (wr_nx != rd_nx) begin
                if (push && (rd_nx == wr_ptr)) head <= ev;
                else                           head <= mem[rd_nx[AW-1:0]];
            end
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    assign ev_code = head.code;
    assign ev_ext  = head.ext;
    assign ev_make = head.make;

endmodule

// File: tb/tb_ps2_key_event_unit.sv
// tb_ps2_key_event_unit: drives PS/2 frames into ps2_key_event_unit and
// scoreboards the emitted events, key bitmap, frame errors and overflow.
module tb_ps2_key_event_unit;

    localparam int NUM_KEYS = 9;
    localparam logic [9*NUM_KEYS-1:0] KT = {9'h059, 9'h026, 9'h01E,
                                            9'h016, 9'h029, 9'h05A,
                                            9'h07A, 9'h072, 9'h069};
    localparam int DEPTH = 4;
    localparam int FILT  = 8;
    localparam int TMO   = 2000;
    localparam int HALF  = 20;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit TYPEMATIC = 1'b1;
`else
    localparam bit TYPEMATIC = 1'b0;
`endif

    logic                CLOCK_50 = 1'b0;
    logic                reset    = 1'b1;
    logic                PS2_CLK  = 1'b1;
    logic                PS2_DAT  = 1'b1;
    logic                ev_ready = 1'b0;
    logic                ev_valid;
    logic [7:0]          ev_code;
    logic                ev_ext;
    logic                ev_make;
    logic [NUM_KEYS-1:0] key_down;
    logic                frame_err;
    logic                overflow;

    int checks     = 0;
    int failures   = 0;
    int err_pulses = 0;
    int popped     = 0;
    int lat;
    logic [9:0]          exp_q[$];
    logic [NUM_KEYS-1:0] mdl_keys = '0;
    logic                mdl_ovf  = 1'b0;

    ps2_key_event_unit #(
        .NUM_KEYS    (NUM_KEYS),
        .KEY_TABLE   (KT),
        .FIFO_DEPTH  (DEPTH),
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_make   (ev_make),
        .key_down  (key_down),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) if (frame_err) err_pulses <= err_pulses + 1;

    // Reference model: bitmap, typematic suppression, FIFO capacity.
    task automatic expect_ev(input logic ext, input logic make, input logic [7:0] code);
        logic rep;
        rep = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (KT[9*i +: 9] == {ext, code}) begin
                if (make && mdl_keys[i]) rep = 1'b1;
                mdl_keys[i] = make;
            end
        end
        if (rep && TYPEMATIC) return;
        if (exp_q.size() >= DEPTH) mdl_ovf = 1'b1;
        else exp_q.push_back({ext, make, code});
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        lat = -1;
        for (int b = 0; b < n; b++) begin
            PS2_DAT = bits[b];
            repeat (HALF / 2) @(negedge CLOCK_50);
            PS2_CLK = 1'b0;
            for (int j = 1; j <= HALF; j++) begin
                @(negedge CLOCK_50);
                if (b == n - 1 && lat < 0 && ev_valid) lat = j;
            end
            PS2_CLK = 1'b1;
            repeat (HALF / 2) @(negedge CLOCK_50);
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        send_bits({1'b1, (~^d) ^ bad_par, d, 1'b0}, 11);
        repeat (HALF) @(negedge CLOCK_50);
    endtask

    task automatic drain(input string name);
        logic [9:0] e;
        int budget;
        budget = 400;
        ev_ready = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            if (ev_valid) begin
                e = exp_q.pop_front();
                popped++;
                checks++;
                if ({ev_ext, ev_make, ev_code} !== e) begin
                    failures++;
                    $display("FAIL %s event: got ext=%0d make=%0d code=%h, expected ext=%0d make=%0d code=%h",
                             name, ev_ext, ev_make, ev_code, e[9], e[8], e[7:0]);
                end
            end
            @(negedge CLOCK_50);
            budget--;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s drain: %0d events never appeared, expected 0 left", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s extra: ev_valid=%b code=%h, expected ev_valid=0", name, ev_valid, ev_code);
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        checks += 7;
        if (ev_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b expected 0", ev_valid); end
        if (ev_code !== 8'h00) begin failures++; $display("FAIL rst_code got %h expected 00", ev_code); end
        if (ev_ext !== 1'b0) begin failures++; $display("FAIL rst_ext got %b expected 0", ev_ext); end
        if (ev_make !== 1'b0) begin failures++; $display("FAIL rst_make got %b expected 0", ev_make); end
        if (key_down !== '0) begin failures++; $display("FAIL rst_keys got %b expected 0", key_down); end
        if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_ferr got %b expected 0", frame_err); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got %b expected 0", overflow); end
    endtask

    task automatic test_latency();
        send_frame(8'h1C, 1'b0);
        expect_ev(1'b0, 1'b1, 8'h1C);
        checks += 2;
        if (lat !== FILT + 3) begin failures++; $display("FAIL lat_1c got %0d expected %0d", lat, FILT + 3); end
        if (key_down !== mdl_keys) begin failures++; $display("FAIL keys_1c got %b expected %b", key_down, mdl_keys); end
        drain("lat_1c");
    endtask

    task automatic test_make_break();
        send_frame(8'h69, 1'b0);
        expect_ev(1'b0, 1'b1, 8'h69);
        checks++;
        if (key_down[0] !== 1'b1) begin failures++; $display("FAIL make_69 key0 got %b expected 1", key_down[0]); end
        send_frame(8'hF0, 1'b0);
        send_frame(8'h69, 1'b0);
        expect_ev(1'b0, 1'b0, 8'h69);
        checks++;
        if (key_down !== mdl_keys) begin failures++; $display("FAIL brk_69 keys got %b expected %b", key_down, mdl_keys); end
        drain("mb_69");
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        expect_ev(1'b1, 1'b1, 8'h75);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        expect_ev(1'b1, 1'b0, 8'h75);
        send_frame(8'hAA, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h12, 1'b0);
        checks++;
        if (key_down !== mdl_keys) begin failures++; $display("FAIL ext_keys got %b expected %b", key_down, mdl_keys); end
        drain("ext_75");
    endtask

    task automatic test_parity();
        int e0;
        e0 = err_pulses;
        send_frame(8'h29, 1'b1);
        checks += 3;
        if (err_pulses !== e0 + 1) begin failures++; $display("FAIL par_err pulses got %0d expected %0d", err_pulses - e0, 1); end
        if (ev_valid !== 1'b0) begin failures++; $display("FAIL par_noev got %b expected 0", ev_valid); end
        if (key_down[4] !== 1'b0) begin failures++; $display("FAIL par_key4 got %b expected 0", key_down[4]); end
        send_frame(8'h29, 1'b0);
        expect_ev(1'b0, 1'b1, 8'h29);
        checks++;
        if (key_down[4] !== 1'b1) begin failures++; $display("FAIL good_key4 got %b expected 1", key_down[4]); end
        drain("par_29");
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h16, 8'h1E};
        foreach (codes[k]) begin
            send_frame(codes[k], 1'b0);
            expect_ev(1'b0, 1'b1, codes[k]);
        end
        checks += 2;
        if (overflow !== mdl_ovf) begin failures++; $display("FAIL ovf_set got %b expected %b", overflow, mdl_ovf); end
        if (key_down !== mdl_keys) begin failures++; $display("FAIL ovf_keys got %b expected %b", key_down, mdl_keys); end
        drain("ovf");
        checks++;
        if (overflow !== mdl_ovf) begin failures++; $display("FAIL ovf_sticky got %b expected %b", overflow, mdl_ovf); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_pulses;
        send_bits(11'h01A, 5);
        repeat (TMO + 10) @(negedge CLOCK_50);
        checks += 2;
        if (err_pulses !== e0 + 1) begin failures++; $display("FAIL tmo_err pulses got %0d expected 1", err_pulses - e0); end
        if (ev_valid !== 1'b0) begin failures++; $display("FAIL tmo_noev got %b expected 0", ev_valid); end
        send_frame(8'h5A, 1'b0);
        expect_ev(1'b0, 1'b1, 8'h5A);
        checks++;
        if (key_down[3] !== 1'b1) begin failures++; $display("FAIL tmo_key3 got %b expected 1", key_down[3]); end
        drain("tmo_5a");
    endtask

    task automatic test_typematic();
        int p0;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h5A, 1'b0);
        expect_ev(1'b0, 1'b0, 8'h5A);
        p0 = popped;
        repeat (3) begin
            send_frame(8'h5A, 1'b0);
            expect_ev(1'b0, 1'b1, 8'h5A);
        end
        checks++;
        if (key_down !== mdl_keys) begin failures++; $display("FAIL typ_keys got %b expected %b", key_down, mdl_keys); end
        drain("typ_5a");
        checks++;
        if (popped - p0 !== (TYPEMATIC ? 2 : 4)) begin
            failures++;
            $display("FAIL typ_count got %0d expected %0d", popped - p0, TYPEMATIC ? 2 : 4);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_make_break();
        test_extended();
        test_parity();
        test_overflow();
        test_timeout();
        test_typematic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
